ps2_kbd_tx: RTL

Keyboard-side PS/2 transmitter. It accepts one ASCII character at a time over a valid/ready handshake and translates it to a Set-2 scan code. It then emits the full make/break byte sequence as device-to-host PS/2 frames on ps2_clk/ps2_data. It drives the PS/2 receiver and keyboard decode path in simulation and on board, without a physical keyboard.

---
 rtl/ps2_kbd_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_tx.sv
// Keyboard-side PS/2 transmitter: ASCII in, Set-2 make/F0/make frames out on ps2_clk/ps2_data.
// Optional macro PS2_TX_SHIFT_EN: uppercase letters are wrapped in left-shift make/break (6 bytes).
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_ascii,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       unsupported
);
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef PS2_TX_SHIFT_EN
    localparam int NB = 6;
`else
    localparam int NB = 3;
`endif
    localparam int BW = $clog2(NB);
    localparam logic [HW-1:0] HALF_INIT = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_INIT  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t          state, state_n;
    logic [HW-1:0]   half_cnt, half_cnt_n;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    logic            phase_low, phase_low_n;
    logic [3:0]      bit_idx, bit_idx_n;
    logic [BW-1:0]   byte_idx, byte_idx_n, last_idx, last_idx_n;
    logic [7:0]      seq [NB];
    logic [7:0]      seq_n [NB];
    logic            clk_q, clk_n, data_q, data_n, unsup_q, unsup_n;

    logic [7:0]      letter, code, cur;
    logic            mapped;
    logic [10:0]     frame_w;

    // Fold lowercase onto uppercase so one table serves both.
    assign letter = (in_ascii >= 8'h61 && in_ascii <= 8'h7A) ? (in_ascii - 8'h20) : in_ascii;

    always_comb begin
        code   = 8'h00;
        mapped = 1'b1;
        case (letter)
            8'h41: code = 8'h1C;  8'h42: code = 8'h32;  8'h43: code = 8'h21;
            8'h44: code = 8'h23;  8'h45: code = 8'h24;  8'h46: code = 8'h2B;
            8'h47: code = 8'h34;  8'h48: code = 8'h33;  8'h49: code = 8'h43;
            8'h4A: code = 8'h3B;  8'h4B: code = 8'h42;  8'h4C: code = 8'h4B;
            8'h4D: code = 8'h3A;  8'h4E: code = 8'h31;  8'h4F: code = 8'h44;
            8'h50: code = 8'h4D;  8'h51: code = 8'h15;  8'h52: code = 8'h2D;
            8'h53: code = 8'h1B;  8'h54: code = 8'h2C;  8'h55: code = 8'h3C;
            8'h56: code = 8'h2A;  8'h57: code = 8'h1D;  8'h58: code = 8'h22;
            8'h59: code = 8'h35;  8'h5A: code = 8'h1A;
            8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1E;
            8'h33: code = 8'h26;  8'h34: code = 8'h25;  8'h35: code = 8'h2E;
            8'h36: code = 8'h36;  8'h37: code = 8'h3D;  8'h38: code = 8'h3E;
            8'h39: code = 8'h46;
            8'h20: code = 8'h29;  8'h0D: code = 8'h5A;  8'h08: code = 8'h66;
            default: mapped = 1'b0;
        endcase
    end

    assign cur     = seq[byte_idx];
    assign frame_w = {1'b1, ~^cur, cur, 1'b0};

    always_comb begin
        state_n     = state;
        half_cnt_n  = half_cnt;
        gap_cnt_n   = gap_cnt;
        phase_low_n = phase_low;
        bit_idx_n   = bit_idx;
        byte_idx_n  = byte_idx;
        last_idx_n  = last_idx;
        seq_n       = seq;
        clk_n       = clk_q;
        data_n      = data_q;
        unsup_n     = 1'b0;
        case (state)
            IDLE: begin
                clk_n  = 1'b1;
                data_n = 1'b1;
                if (in_valid) begin
                    if (mapped) begin
                        state_n     = FRAME;
                        data_n      = 1'b0;
                        half_cnt_n  = HALF_INIT;
                        phase_low_n = 1'b0;
                        bit_idx_n   = 4'd0;
                        byte_idx_n  = '0;
                        seq_n[0]    = code;
                        seq_n[1]    = 8'hF0;
                        seq_n[2]    = code;
                        last_idx_n  = BW'(2);
`ifdef PS2_TX_SHIFT_EN
                        if (in_ascii >= 8'h41 && in_ascii <= 8'h5A) begin
                            seq_n[0]   = 8'h12;
                            seq_n[1]   = code;
                            seq_n[2]   = 8'hF0;
                            seq_n[3]   = code;
                            seq_n[4]   = 8'hF0;
                            seq_n[5]   = 8'h12;
                            last_idx_n = BW'(5);
                        end
`endif
                    end else begin
                        unsup_n = 1'b1;
                    end
                end
            end
            FRAME: begin
                if (half_cnt != '0) begin
                    half_cnt_n = half_cnt - 1'b1;
                end else if (!phase_low) begin
                    phase_low_n = 1'b1;
                    clk_n       = 1'b0;
                    half_cnt_n  = HALF_INIT;
                end else if (bit_idx == 4'd10) begin
                    state_n   = GAP;
                    clk_n     = 1'b1;
                    data_n    = 1'b1;
                    gap_cnt_n = GAP_INIT;
                end else begin
                    // Data only moves together with the rising ps2_clk.
                    bit_idx_n   = bit_idx + 4'd1;
                    phase_low_n = 1'b0;
                    clk_n       = 1'b1;
                    data_n      = frame_w[bit_idx + 4'd1];
                    half_cnt_n  = HALF_INIT;
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end else if (byte_idx == last_idx) begin
                    state_n = IDLE;
                end else begin
                    state_n     = FRAME;
                    byte_idx_n  = byte_idx + BW'(1);
                    clk_n       = 1'b1;
                    data_n      = 1'b0;
                    half_cnt_n  = HALF_INIT;
                    phase_low_n = 1'b0;
                    bit_idx_n   = 4'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            half_cnt  <= '0;
            gap_cnt   <= '0;
            phase_low <= 1'b0;
            bit_idx   <= 4'd0;
            byte_idx  <= '0;
            last_idx  <= '0;
            for (int i = 0; i < NB; i++) seq[i] <= 8'h00;
            clk_q     <= 1'b1;
            data_q    <= 1'b1;
            unsup_q   <= 1'b0;
        end else begin
            state     <= state_n;
            half_cnt  <= half_cnt_n;
            gap_cnt   <= gap_cnt_n;
            phase_low <= phase_low_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            last_idx  <= last_idx_n;
            seq       <= seq_n;
            clk_q     <= clk_n;
            data_q    <= data_n;
            unsup_q   <= unsup_n;
        end
    end

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2_clk     = clk_q;
    assign ps2_data    = data_q;
    assign unsupported = unsup_q;
endmodule
